ysyx_220066_div: RTL and testbench
==================================

# ysyx_220066_div

Multi-cycle iterative divider that serves the EX stage's M-extension divide/remainder requests (ALUctr[5]=1, ALUctr[2]=1). EX issues an operation over a valid/ready request channel and stalls the pipeline until this unit returns the 64-bit result over a valid/ready response channel. It implements radix-2 restoring division on operand magnitudes, then applies a sign correction. It also reports divide-by-zero on a dedicated `error` flag, which EX folds into its error path.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset; rst=0 resets the block on the next rising edge of clk.
- flush  in  1  kills any in-flight op; returns the unit to IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; equals (state==IDLE) && rst.
- src1  in  64  dividend.
- src2  in  64  divisor.
- op  in  2  {is_rem, is_unsigned}; this is ALUctr[1:0]: 00=div, 01=divu, 10=rem, 11=remu.
- is_w  in  1  32-bit W variant; this is ALUctr[4].
- out_valid  out  1  response valid.
- out_ready  in  1  consumer accepts; driven by EX as ~block.
- result  out  64  quotient or remainder.
- error  out  1  divisor was zero; valid only with out_valid.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY on in_valid && in_ready && ~flush.
  - On that edge, latch op, is_w, operand signs, magnitudes, and divisor-zero.
  - Set the iteration counter N: 64, or 32 when is_w=1.
- W operands: use src[31:0]. Sign-extend for signed ops; zero-extend for unsigned ops.
- BUSY: one restoring step per cycle, then decrement the counter.
  - On the last step, register the sign-corrected result and go to DONE.
- Sign rules for signed ops:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, forced regardless of the algorithm:
  - Divisor zero: quotient = all ones, remainder = dividend, error = 1.
  - Signed overflow (dividend = most-negative value, divisor = -1): quotient = dividend, remainder = 0, error = 0.
- W results: the 32-bit result is sign-extended to 64 bits for all four ops.
- DONE: out_valid=1 and result/error are held stable. Go to IDLE on out_ready.
- flush:
  - Next state is IDLE from any state and out_valid drops.
  - It beats an in_valid presented in the same cycle; that request is not accepted.
- Reset (rst=0), including mid-operation: state=IDLE, out_valid=0, result=0, error=0, counter=0. in_ready=0 while rst=0.

## Timing
- Request accepted at edge T. Without fast path, out_valid is first high in cycle T+N+1: T+65 for 64-bit, T+33 for W.
- Back-to-back ops: in_ready rises in the cycle after the DONE handshake. There is no accept in the same cycle as a response.
- in_ready is combinational from state only; there is no path from in_valid to in_ready.
- result and error come straight from registers.

## Configuration
- `YSYX_220066_DIV_FASTPATH_EN` defined: divisor zero, signed overflow, and |dividend| < |divisor| go directly IDLE → DONE. out_valid is high at T+1, with the same values as the slow path.
- Not defined: every op takes the full N iterations. Special-case results are still forced.

## Structure
- Shared defines file `ysyx_220066_defines`: op encodings (DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11), state encodings, and the 64/32 iteration counts.
- One combinational sub-module, `ysyx_220066_div_step`: takes partial remainder, quotient, and divisor; returns the next partial remainder and quotient bit.
- Top: FSM, counter, operand prep, sign correction.

## Test plan
- divu 100/7 → result=14, out_valid first at T+65. remu 100/7 → 2.
- div -7/2 → 0xFFFF_FFFF_FFFF_FFFD. rem -7/2 → 0xFFFF_FFFF_FFFF_FFFF. error=0.
- divw src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_8000_0000; remw → 0. Latency 33 with the macro off.
- div 5/0 → result=0xFFFF_FFFF_FFFF_FFFF, error=1. rem 5/0 → 5. With the macro on, out_valid at T+1.
- Hold out_ready=0 for 3 cycles in DONE → result stable, in_ready=0. Release → the next request is accepted one cycle later.
- flush at BUSY iteration 10 → IDLE next cycle, no out_valid. rst=0 mid-BUSY → all outputs 0. A following divu 9/3 returns 3.

Source files
------------

// File: rtl/ysyx_220066_defines.sv
// Shared encodings for the ysyx_220066 divider: op codes, FSM states and
// iteration counts.
package ysyx_220066_defines;

  // op = {is_rem, is_unsigned}, taken straight from ALUctr[1:0]
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  // Counter wide enough to hold the full 64-step count
  localparam int              CNT_W  = 7;
  localparam logic [CNT_W-1:0] ITER_D = 7'd64;
  localparam logic [CNT_W-1:0] ITER_W = 7'd32;

endpackage

// File: rtl/ysyx_220066_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, and shift the
// resulting quotient bit into the low end of the quotient register.
module ysyx_220066_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  // The shifted remainder can exceed XLEN bits, so the trial is one bit wider;
  // after a successful subtract the result is below the divisor and fits.
  logic [XLEN:0] trial;
  logic          q_bit;

  // Trial subtract and restore
  always_comb begin
    trial   = {rem_in, quo_in[XLEN-1]};
    q_bit   = (trial >= {1'b0, divisor});
    rem_out = q_bit ? (trial[XLEN-1:0] - divisor) : trial[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], q_bit};
  end

endmodule

// File: rtl/ysyx_220066_div.sv
// Iterative radix-2 restoring divider for the EX stage (div/divu/rem/remu and
// their W forms). Divides operand magnitudes, then sign-corrects; divide by
// zero and signed overflow results are forced.
// Optional: define YSYX_220066_DIV_FASTPATH_EN to let divide-by-zero, signed
// overflow and |dividend| < |divisor| skip the iterations (IDLE -> DONE).
module ysyx_220066_div
  import ysyx_220066_defines::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      op,
  input  logic            is_w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            error
);

  localparam int HALF = XLEN / 2;

  div_state_e state, state_nx;
  logic [CNT_W-1:0] cnt;

  logic                   is_rem, is_uns, accept, fast_hit;
  logic signed [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0]        a_mag, b_mag, min_val;
  logic                   sa, sb, dz, ovf;

  logic [XLEN-1:0] rem_q, quo_q, b_mag_q, a_ext_q;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic            is_rem_q, is_uns_q, is_w_q, sa_q, sb_q, dz_q, ovf_q;

  // Sign correction, special-case forcing and W sign extension of the result
  function automatic logic [XLEN-1:0] fix_result(
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag,
    input logic [XLEN-1:0] dividend,
    input logic            f_rem,
    input logic            f_uns,
    input logic            f_sa,
    input logic            f_sb,
    input logic            f_w,
    input logic            f_dz,
    input logic            f_ovf
  );
    logic [XLEN-1:0] q, r, res;
    q = (!f_uns && (f_sa ^ f_sb)) ? -q_mag : q_mag;
    r = (!f_uns && f_sa) ? -r_mag : r_mag;
    if (f_dz) begin
      q = '1;
      r = dividend;
    end else if (f_ovf) begin
      q = dividend;
      r = '0;
    end
    res = f_rem ? r : q;
    if (f_w) begin
      res = {{HALF{res[HALF-1]}}, res[HALF-1:0]};
    end
    return res;
  endfunction

  // Operand prep: extend W operands, take magnitudes, detect special cases
  always_comb begin
    is_rem = (op == OP_REM) || (op == OP_REMU);
    is_uns = (op == OP_DIVU) || (op == OP_REMU);
    if (is_w) begin
      a_ext = is_uns ? {{HALF{1'b0}}, src1[HALF-1:0]}
                     : {{HALF{src1[HALF-1]}}, src1[HALF-1:0]};
      b_ext = is_uns ? {{HALF{1'b0}}, src2[HALF-1:0]}
                     : {{HALF{src2[HALF-1]}}, src2[HALF-1:0]};
      min_val = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end else begin
      a_ext   = src1;
      b_ext   = src2;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    sa    = !is_uns && a_ext[XLEN-1];
    sb    = !is_uns && b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    dz    = (b_ext == '0);
    ovf   = !is_uns && (a_ext == min_val) && (b_ext == '1);
  end

`ifdef YSYX_220066_DIV_FASTPATH_EN
  assign fast_hit = dz || ovf || (a_mag < b_mag);
`else
  assign fast_hit = 1'b0;
`endif

  assign in_ready  = (state == S_IDLE) && rst;
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;

  ysyx_220066_div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (b_mag_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = fast_hit ? S_DONE : S_BUSY;
      S_BUSY: if (cnt == CNT_W'(1)) state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) begin
      state_nx = S_IDLE;
    end
  end

  // Iteration counter and registered result/error
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      result <= '0;
      error  <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= fast_hit ? '0 : (is_w ? ITER_W : ITER_D);
      if (fast_hit) begin
        result <= fix_result('0, a_mag, a_ext, is_rem, is_uns, sa, sb, is_w, dz, ovf);
        error  <= dz;
      end
    end else if (state == S_BUSY) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        result <= fix_result(quo_nx, rem_nx, a_ext_q, is_rem_q, is_uns_q,
                             sa_q, sb_q, is_w_q, dz_q, ovf_q);
        error  <= dz_q;
      end
    end
  end

  // Operand latch on accept, one restoring step per BUSY cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q    <= '0;
      quo_q    <= is_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
      b_mag_q  <= b_mag;
      a_ext_q  <= a_ext;
      is_rem_q <= is_rem;
      is_uns_q <= is_uns;
      is_w_q   <= is_w;
      sa_q     <= sa;
      sb_q     <= sb;
      dz_q     <= dz;
      ovf_q    <= ovf;
    end else if (state == S_BUSY) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_div.sv
// Scoreboard bench for ysyx_220066_div: a driver pushes expected responses,
// a monitor pops and compares whenever the divider presents a result.
module tb_ysyx_220066_div;

`ifdef YSYX_220066_DIV_FASTPATH_EN
  localparam bit FASTPATH = 1'b1;
`else
  localparam bit FASTPATH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic [1:0]  op = 2'b00;
  logic        is_w = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        error;

  ysyx_220066_div #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .op        (op),
    .is_w      (is_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    logic        err;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   hs_cyc = -100;
  int   hold_left = 0;
  bit   seen = 1'b0;

  // Reference: RISC-V M-extension semantics via plain integer arithmetic
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] o, input logic w,
                                output logic [63:0] res, output logic err,
                                output logic fast);
    int signed     s1, s2;
    int unsigned   u1, u2;
    longint signed l1, l2;
    logic [31:0]   q32, r32;
    logic [63:0]   q64, r64, m1, m2;
    logic          uns, rm;
    uns = o[0];
    rm  = o[1];
    err = 1'b0;
    fast = 1'b0;
    if (w) begin
      s1 = a[31:0]; s2 = b[31:0]; u1 = a[31:0]; u2 = b[31:0];
      if (u2 == 0) begin
        q32 = '1; r32 = u1; err = 1'b1; fast = 1'b1;
      end else if (!uns && s1 == 32'sh8000_0000 && s2 == -1) begin
        q32 = u1; r32 = 0; fast = 1'b1;
      end else if (uns) begin
        q32 = u1 / u2; r32 = u1 % u2;
        fast = (u1 < u2);
      end else begin
        q32 = s1 / s2; r32 = s1 % s2;
        m1 = (s1 < 0) ? -longint'(s1) : longint'(s1);
        m2 = (s2 < 0) ? -longint'(s2) : longint'(s2);
        fast = (m1 < m2);
      end
      q64 = {{32{q32[31]}}, q32};
      r64 = {{32{r32[31]}}, r32};
    end else begin
      l1 = a; l2 = b;
      if (b == 0) begin
        q64 = '1; r64 = a; err = 1'b1; fast = 1'b1;
      end else if (!uns && l1 == 64'sh8000_0000_0000_0000 && l2 == -1) begin
        q64 = a; r64 = 0; fast = 1'b1;
      end else if (uns) begin
        q64 = a / b; r64 = a % b;
        fast = (a < b);
      end else begin
        q64 = l1 / l2; r64 = l1 % l2;
        m1 = (l1 < 0) ? -a : a;
        m2 = (l2 < 0) ? -b : b;
        fast = (m1 < m2);
      end
    end
    res = rm ? r64 : q64;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Wait for in_ready, present one request, and queue its expected response
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] o, input logic w,
                       input logic use_exp, input logic [63:0] exp_res,
                       input logic exp_err, input logic push, input logic chk_b2b);
    int          n;
    exp_t        e;
    logic [63:0] mres;
    logic        merr, mfast;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles, expected 1", in_ready, n);
      return;
    end
    src1 = a; src2 = b; op = o; is_w = w; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model(a, b, o, w, mres, merr, mfast);
    if (use_exp) begin
      mres = exp_res;
      merr = exp_err;
    end
    if (push) begin
      e.res   = mres;
      e.err   = merr;
      e.lat   = (FASTPATH && mfast) ? 0 : (w ? 32 : 64);
      e.t_acc = cyc;
      sb.push_back(e);
    end
    if (chk_b2b) begin
      tests++;
      if (cyc != hs_cyc + 1) begin
        fails++;
        $display("FAIL b2b_accept: accepted at cycle %0d, expected %0d", cyc, hs_cyc + 1);
      end
    end
  endtask

  // Monitor: compare the head of the scoreboard whenever out_valid is high
  initial begin
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_response: out_valid=1 result=%h, expected no response", result);
          out_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1'b1;
            tests++;
            if (cyc - sb[0].t_acc != sb[0].lat) begin
              fails++;
              $display("FAIL latency: got %0d cycles, expected %0d", cyc - sb[0].t_acc, sb[0].lat);
            end
          end
          chk("result", result, sb[0].res);
          chk("error", {63'b0, error}, {63'b0, sb[0].err});
          chk("in_ready_while_done", {63'b0, in_ready}, 64'd0);
          if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
          end else begin
            out_ready = ($urandom_range(0, 3) != 0);
          end
          if (out_ready) begin
            hs_cyc = cyc + 1;
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Stimulus
  initial begin
    logic [63:0] a, b;
    int          k, n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'b0, in_ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_error", {63'b0, error}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with hand-derived expectations
    issue(64'd100, 64'd7, 2'b01, 1'b0, 1'b1, 64'd14, 1'b0, 1'b1, 1'b0);
    issue(64'd100, 64'd7, 2'b11, 1'b0, 1'b1, 64'd2, 1'b0, 1'b1, 1'b0);
    issue(-64'sd7, 64'd2, 2'b00, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1, 1'b0);
    issue(-64'sd7, 64'd2, 2'b10, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    issue(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b1, 1'b1,
          64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 1'b0);
    issue(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, 1'b1,
          64'd0, 1'b0, 1'b1, 1'b0);
    issue(64'd5, 64'd0, 2'b00, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    issue(64'd5, 64'd0, 2'b10, 1'b0, 1'b1, 64'd5, 1'b1, 1'b1, 1'b0);
    issue(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 1'b1,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    // Backpressure: hold DONE for 3 cycles, then the next request follows
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    hold_left = 3;
    issue(64'd1000, 64'd10, 2'b01, 1'b0, 1'b1, 64'd100, 1'b0, 1'b1, 1'b0);
    issue(64'd9, 64'd3, 2'b01, 1'b0, 1'b1, 64'd3, 1'b0, 1'b1, 1'b1);

    // Flush in the middle of an iteration run
    issue(64'd1000, 64'd3, 2'b01, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    in_valid = 1'b1;
    src1 = 64'd50; src2 = 64'd5; op = 2'b01; is_w = 1'b0;
    @(posedge clk);
    #1;
    chk("flush_beats_in_valid", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b0;
    flush = 1'b0;
    repeat (80) @(posedge clk);

    // Reset in the middle of an iteration run
    issue(64'd1000, 64'd3, 2'b01, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midreset_result", result, 64'd0);
    chk("midreset_error", {63'b0, error}, 64'd0);
    chk("midreset_in_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    issue(64'd9, 64'd3, 2'b01, 1'b0, 1'b1, 64'd3, 1'b0, 1'b1, 1'b0);

    // Randomized operations checked against the reference model
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      k = $urandom_range(0, 7);
      case (k)
        0: b = '0;
        1: b = 64'($urandom_range(1, 255));
        2: a = 64'($urandom_range(0, 255));
        3: begin a = 64'h8000_0000_0000_0000; b = '1; end
        4: begin a = 64'h0000_0000_8000_0000; b = '1; end
        5: b = {32'b0, $urandom};
        default: ;
      endcase
      issue(a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
    end

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
